// File: rtl/drop_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : drop_scheduler
// Brief    : Gravity and lock-delay scheduler for the active Tetris piece.
//            Counts 10 ms ticks and asks the board to drop the piece one row
//            or to lock it, each through a req/ack handshake.
// Options  : LOCK_RESET_EN - when defined, move_done restarts the lock delay
//            (at most 15 times per piece).
// Revision : 1.0 - initial release
// ============================================================================
module drop_scheduler #(
  parameter int unsigned LEVEL_W    = 4,
  parameter int unsigned BASE_TICKS = 100,
  parameter int unsigned STEP_TICKS = 8,
  parameter int unsigned MIN_TICKS  = 5,
  parameter int unsigned SOFT_TICKS = 5,
  parameter int unsigned LOCK_TICKS = 50,
  parameter int unsigned CNT_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_10ms,
  input  logic [LEVEL_W-1:0] level,
  input  logic               spawn,
  input  logic               grounded,
  input  logic               soft_drop,
  input  logic               pause,
  input  logic               move_done,
  input  logic               drop_ack,
  input  logic               lock_ack,
  output logic               drop_req,
  output logic               lock_req,
  output logic [2:0]         state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FALL      = 3'd1,
    S_DROP_WAIT = 3'd2,
    S_LOCK      = 3'd3,
    S_LOCK_WAIT = 3'd4
  } state_t;

  localparam logic [15:0] C_BASE = 16'(BASE_TICKS);
  localparam logic [15:0] C_STEP = 16'(STEP_TICKS);
  localparam logic [15:0] C_MIN  = 16'(MIN_TICKS);
  localparam logic [15:0] C_SOFT = 16'(SOFT_TICKS);
  localparam logic [15:0] C_LOCK = 16'(LOCK_TICKS);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   fall_cnt_q, fall_cnt_d;
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic               drop_req_q, drop_req_d;
  logic               lock_req_q, lock_req_d;

  logic [15:0]        w_level_prod;
  logic [15:0]        w_norm;
  logic [15:0]        w_eff;
  logic [15:0]        w_fall_next;
  logic [15:0]        w_lock_next;
  logic               w_active_tick;

`ifdef LOCK_RESET_EN
  logic [3:0]         mv_cnt_q, mv_cnt_d;
`else
  logic               unused_move_done;
  assign unused_move_done = move_done;
`endif

  // Drop interval: level-scaled, clamped at the floor, shortened by soft drop.
  always_comb begin
    w_level_prod = 16'(level) * C_STEP;
    if (w_level_prod > (C_BASE - C_MIN)) begin
      w_norm = C_MIN;
    end else begin
      w_norm = C_BASE - w_level_prod;
    end
    w_eff = w_norm;
    if (soft_drop && (C_SOFT < w_norm)) begin
      w_eff = C_SOFT;
    end
  end

  assign w_active_tick = tick_10ms & ~pause;
  assign w_fall_next   = 16'(fall_cnt_q) + 16'd1;
  assign w_lock_next   = 16'(lock_cnt_q) + 16'd1;

  // Next-state, counter and request logic; requests are registered outputs.
  always_comb begin
    state_d    = state_q;
    fall_cnt_d = fall_cnt_q;
    lock_cnt_d = lock_cnt_q;
    drop_req_d = drop_req_q;
    lock_req_d = lock_req_q;
`ifdef LOCK_RESET_EN
    mv_cnt_d   = mv_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (spawn) begin
          state_d    = S_FALL;
          fall_cnt_d = '0;
`ifdef LOCK_RESET_EN
          mv_cnt_d   = '0;
`endif
        end
      end
      S_FALL: begin
        // Grounding beats a coincident tick.
        if (grounded) begin
          state_d    = S_LOCK;
          lock_cnt_d = '0;
        end else if (w_active_tick) begin
          // >= so that a shrunken interval fires on the very next tick.
          if (w_fall_next >= w_eff) begin
            fall_cnt_d = '0;
            drop_req_d = 1'b1;
            state_d    = S_DROP_WAIT;
          end else begin
            fall_cnt_d = w_fall_next[CNT_W-1:0];
          end
        end
      end
      S_DROP_WAIT: begin
        // Ticks here are discarded; the count stays frozen until the ack.
        if (drop_ack) begin
          drop_req_d = 1'b0;
          state_d    = S_FALL;
        end
      end
      S_LOCK: begin
        if (!grounded) begin
          // Slid off a ledge: restart gravity from a clean interval.
          state_d    = S_FALL;
          fall_cnt_d = '0;
        end
`ifdef LOCK_RESET_EN
        else if (move_done && (mv_cnt_q != 4'd15)) begin
          lock_cnt_d = '0;
          mv_cnt_d   = mv_cnt_q + 4'd1;
        end
`endif
        else if (w_active_tick) begin
          if (w_lock_next >= C_LOCK) begin
            lock_req_d = 1'b1;
            state_d    = S_LOCK_WAIT;
          end else begin
            lock_cnt_d = w_lock_next[CNT_W-1:0];
          end
        end
      end
      S_LOCK_WAIT: begin
        if (lock_ack) begin
          lock_req_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        drop_req_d = 1'b0;
        lock_req_d = 1'b0;
      end
    endcase
  end

  // State and counter registers; reset abandons any pending handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      fall_cnt_q <= '0;
      lock_cnt_q <= '0;
      drop_req_q <= 1'b0;
      lock_req_q <= 1'b0;
`ifdef LOCK_RESET_EN
      mv_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      fall_cnt_q <= fall_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      drop_req_q <= drop_req_d;
      lock_req_q <= lock_req_d;
`ifdef LOCK_RESET_EN
      mv_cnt_q   <= mv_cnt_d;
`endif
    end
  end

  assign drop_req = drop_req_q;
  assign lock_req = lock_req_q;
  assign state_o  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_drop_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_drop_scheduler
// Brief    : Directed self-checking bench for drop_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_drop_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_10ms;
  logic [3:0] level;
  logic       spawn;
  logic       grounded;
  logic       soft_drop;
  logic       pause;
  logic       move_done;
  logic       drop_ack;
  logic       lock_ack;
  logic       drop_req;
  logic       lock_req;
  logic [2:0] state_o;

  int errors = 0;
  int checks = 0;

  drop_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .tick_10ms (tick_10ms),
    .level     (level),
    .spawn     (spawn),
    .grounded  (grounded),
    .soft_drop (soft_drop),
    .pause     (pause),
    .move_done (move_done),
    .drop_ack  (drop_ack),
    .lock_ack  (lock_ack),
    .drop_req  (drop_req),
    .lock_req  (lock_req),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  // Requests must never overlap.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      if (drop_req === 1'b1 && lock_req === 1'b1) begin
        errors++;
        $display("FAIL req_exclusive: drop_req=%b lock_req=%b required not both 1", drop_req, lock_req);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick_10ms = 1'b1; level = 4'd0; spawn = 1'b0; grounded = 1'b0;
    soft_drop = 1'b0; pause = 1'b0; move_done = 1'b0; drop_ack = 1'b0; lock_ack = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Counts clock edges until the selected request rises (bounded).
  task automatic wait_req(input bit is_lock, input int max, output int n);
    n = 0;
    while (((is_lock ? lock_req : drop_req) !== 1'b1) && n < max) begin
      step();
      n++;
    end
  endtask

  task automatic start_piece();
    spawn = 1'b1;
    step();
    spawn = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", state_o); end
    checks++;
    if (drop_req !== 1'b0) begin errors++; $display("FAIL reset_drop_req: got %b required 0", drop_req); end
    checks++;
    if (lock_req !== 1'b0) begin errors++; $display("FAIL reset_lock_req: got %b required 0", lock_req); end
  endtask

  task automatic test_normal_drop();
    int n;
    bit held;
    do_reset();
    start_piece();
    checks++;
    if (state_o !== 3'd1) begin errors++; $display("FAIL spawn_fall: state=%0d required 1", state_o); end
    wait_req(1'b0, 300, n);
    checks++;
    if (n !== 100) begin errors++; $display("FAIL lvl0_first_drop: edges=%0d required 100", n); end
    checks++;
    if (state_o !== 3'd2) begin errors++; $display("FAIL drop_wait_state: state=%0d required 2", state_o); end
    held = 1'b1;
    repeat (3) begin
      step();
      if (drop_req !== 1'b1) held = 1'b0;
    end
    checks++;
    if (held !== 1'b1) begin errors++; $display("FAIL drop_req_held: held=%b required 1", held); end
    drop_ack = 1'b1;
    step();
    drop_ack = 1'b0;
    checks++;
    if (drop_req !== 1'b0 || state_o !== 3'd1) begin
      errors++; $display("FAIL drop_ack_release: drop_req=%b state=%0d required 0/1", drop_req, state_o);
    end
    wait_req(1'b0, 300, n);
    checks++;
    if (n !== 100) begin errors++; $display("FAIL lvl0_second_drop: edges=%0d required 100", n); end
    drop_ack = 1'b1;
    step();
    drop_ack = 1'b0;
  endtask

  task automatic test_level_scaling();
    int lv [4] = '{12, 15, 5, 11};
    int ex [4] = '{5, 5, 60, 12};
    int n;
    for (int i = 0; i < 4; i++) begin
      do_reset();
      level = 4'(lv[i]);
      start_piece();
      wait_req(1'b0, 300, n);
      checks++;
      if (n !== ex[i]) begin errors++; $display("FAIL level%0d_first: edges=%0d required %0d", lv[i], n, ex[i]); end
      drop_ack = 1'b1;
      step();
      drop_ack = 1'b0;
      wait_req(1'b0, 300, n);
      checks++;
      if (n !== ex[i]) begin errors++; $display("FAIL level%0d_repeat: edges=%0d required %0d", lv[i], n, ex[i]); end
    end
  endtask

  task automatic test_soft_drop();
    int n;
    do_reset();
    soft_drop = 1'b1;
    start_piece();
    wait_req(1'b0, 300, n);
    checks++;
    if (n !== 5) begin errors++; $display("FAIL soft_interval: edges=%0d required 5", n); end
    drop_ack = 1'b1;
    step();
    drop_ack = 1'b0;
    repeat (3) step();
    soft_drop = 1'b0;
    wait_req(1'b0, 300, n);
    checks++;
    if (n + 3 !== 100) begin errors++; $display("FAIL soft_release_total: edges=%0d required 100", n + 3); end
    drop_ack = 1'b1;
    step();
    drop_ack = 1'b0;
    repeat (10) step();
    soft_drop = 1'b1;
    wait_req(1'b0, 300, n);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL soft_shrink_immediate: edges=%0d required 1", n); end
    soft_drop = 1'b0;
  endtask

  task automatic test_lock();
    int n;
    do_reset();
    grounded = 1'b1;
    start_piece();
    checks++;
    if (state_o !== 3'd1) begin errors++; $display("FAIL grounded_spawn_fall: state=%0d required 1", state_o); end
    step();
    checks++;
    if (state_o !== 3'd3) begin errors++; $display("FAIL enter_lock: state=%0d required 3", state_o); end
    wait_req(1'b1, 300, n);
    checks++;
    if (n !== 50) begin errors++; $display("FAIL lock_delay: edges=%0d required 50", n); end
    checks++;
    if (drop_req !== 1'b0 || state_o !== 3'd4) begin
      errors++; $display("FAIL lock_wait_state: drop_req=%b state=%0d required 0/4", drop_req, state_o);
    end
    lock_ack = 1'b1;
    step();
    lock_ack = 1'b0;
    checks++;
    if (lock_req !== 1'b0 || state_o !== 3'd0) begin
      errors++; $display("FAIL lock_ack_idle: lock_req=%b state=%0d required 0/0", lock_req, state_o);
    end
    start_piece();
    step();
    repeat (30) step();
    grounded = 1'b0;
    step();
    checks++;
    if (state_o !== 3'd1 || lock_req !== 1'b0) begin
      errors++; $display("FAIL slide_off: state=%0d lock_req=%b required 1/0", state_o, lock_req);
    end
    wait_req(1'b0, 300, n);
    checks++;
    if (n !== 100) begin errors++; $display("FAIL slide_off_fall_cnt: edges=%0d required 100", n); end
  endtask

  task automatic test_pause();
    int n;
    do_reset();
    start_piece();
    repeat (40) step();
    pause = 1'b1;
    repeat (20) step();
    pause = 1'b0;
    wait_req(1'b0, 300, n);
    checks++;
    if (40 + 20 + n !== 120) begin errors++; $display("FAIL pause_total: edges=%0d required 120", 60 + n); end
    pause = 1'b1;
    drop_ack = 1'b1;
    step();
    drop_ack = 1'b0;
    checks++;
    if (drop_req !== 1'b0 || state_o !== 3'd1) begin
      errors++; $display("FAIL pause_handshake: drop_req=%b state=%0d required 0/1", drop_req, state_o);
    end
    pause = 1'b0;
  endtask

  task automatic test_ignored_inputs();
    int n;
    do_reset();
    start_piece();
    repeat (10) step();
    spawn = 1'b1; drop_ack = 1'b1; lock_ack = 1'b1;
    step();
    spawn = 1'b0; drop_ack = 1'b0; lock_ack = 1'b0;
    checks++;
    if (state_o !== 3'd1) begin errors++; $display("FAIL ignored_state: state=%0d required 1", state_o); end
    wait_req(1'b0, 300, n);
    checks++;
    if (n !== 89) begin errors++; $display("FAIL ignored_count: edges=%0d required 89", n); end
  endtask

  task automatic test_sparse_ticks();
    do_reset();
    level = 4'd12;
    start_piece();
    repeat (4) begin
      tick_10ms = 1'b0; step(); step();
      tick_10ms = 1'b1; step();
    end
    checks++;
    if (drop_req !== 1'b0) begin errors++; $display("FAIL sparse_early: drop_req=%b required 0", drop_req); end
    tick_10ms = 1'b0; step(); step();
    tick_10ms = 1'b1; step();
    checks++;
    if (drop_req !== 1'b1) begin errors++; $display("FAIL sparse_fifth: drop_req=%b required 1", drop_req); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    grounded = 1'b1;
    start_piece();
    step();
    wait_req(1'b1, 300, n);
    checks++;
    if (lock_req !== 1'b1) begin errors++; $display("FAIL reach_lock_wait: lock_req=%b required 1", lock_req); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (lock_req !== 1'b0 || state_o !== 3'd0) begin
      errors++; $display("FAIL reset_mid: lock_req=%b state=%0d required 0/0", lock_req, state_o);
    end
    grounded = 1'b0;
  endtask

`ifdef LOCK_RESET_EN
  task automatic test_move_reset();
    int n;
    int since;
    do_reset();
    grounded = 1'b1;
    start_piece();
    step();
    for (int p = 1; p <= 15; p++) begin
      move_done = 1'b1;
      step();
      move_done = 1'b0;
      if (p < 15) repeat (9) step();
    end
    repeat (9) step();
    move_done = 1'b1;
    step();
    move_done = 1'b0;
    since = 10;
    checks++;
    if (lock_req !== 1'b0) begin errors++; $display("FAIL move_reset_early: lock_req=%b required 0", lock_req); end
    wait_req(1'b1, 300, n);
    since += n;
    checks++;
    if (since !== 50) begin errors++; $display("FAIL move_reset_limit: edges=%0d required 50", since); end
    grounded = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_normal_drop();
    test_level_scaling();
    test_soft_drop();
    test_lock();
    test_pause();
    test_ignored_inputs();
    test_sparse_ticks();
    test_reset_mid();
`ifdef LOCK_RESET_EN
    test_move_reset();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
